// File: rtl/way_victim_pkg.sv
// Shared types and constants for the cache-way victim selection path.
package way_victim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    // XNOR feedback taps of the 8-bit LFSR: bits 7, 3, 2, 1.
    localparam logic [7:0] LFSR_TAPS = 8'h8E;

    // With XNOR feedback the all-ones state maps onto itself forever.
    localparam logic [7:0] LFSR_LOCKUP = 8'hFF;

endpackage

// File: rtl/lfsr8_step.sv
// 8-bit XNOR LFSR that steps once per enabled cycle and exposes a small
// index taken from bits [IDX_W:1].
module lfsr8_step
    import way_victim_pkg::*;
#(
    parameter logic [7:0] SEED  = 8'h00,
    parameter int         IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [IDX_W-1:0] idx
);

    logic [7:0] lfsr;
    logic       fb;

    assign fb  = ~(^(lfsr & LFSR_TAPS));
    assign idx = lfsr[IDX_W:1];

    // Shift left, feedback enters at bit 0; held when not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= {lfsr[6:0], fb};
        end
    end

endmodule

// File: rtl/way_victim_ctrl.sv
// Victim way selection: lowest invalid unlocked way first, otherwise a
// pseudo-random unlocked way found by scanning forward from an LFSR index.
//
// state | meaning
// IDLE  | ready for a request; captures valid/lock bits and random start
// SCAN  | one way examined per cycle until a victim (or none) is found
// RESP  | registered response held until the consumer takes it
module way_victim_ctrl
    import way_victim_pkg::*;
#(
    parameter int         NUM_WAYS = 4,
    parameter int         WAY_W    = $clog2(NUM_WAYS),
    parameter logic [7:0] SEED     = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [NUM_WAYS-1:0] way_valid_i,
    input  logic [NUM_WAYS-1:0] way_lock_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WAY_W-1:0]    rsp_way_bin_o,
    output logic [NUM_WAYS-1:0] rsp_way_oh_o,
    output logic                rsp_invalid_o,
    output logic                rsp_none_o
);

    if (SEED == LFSR_LOCKUP) begin : g_bad_seed
        $error("way_victim_ctrl: SEED 8'hFF locks up the XNOR LFSR");
    end
    if (NUM_WAYS < 2 || NUM_WAYS > 16 || (1 << WAY_W) != NUM_WAYS) begin : g_bad_ways
        $error("way_victim_ctrl: NUM_WAYS must be a power of two in 2..16");
    end

    function automatic logic [WAY_W-1:0] lowest_set(input logic [NUM_WAYS-1:0] v);
        lowest_set = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = WAY_W'(i);
        end
    endfunction

    function automatic logic [NUM_WAYS-1:0] to_onehot(input logic [WAY_W-1:0] b);
        to_onehot    = '0;
        to_onehot[b] = 1'b1;
    endfunction

    state_t              state_q, state_d;
    logic [NUM_WAYS-1:0] valid_q, valid_d;
    logic [NUM_WAYS-1:0] lock_q, lock_d;
    logic [WAY_W-1:0]    ptr_q, ptr_d;
    logic [WAY_W-1:0]    bin_q, bin_d;
    logic [NUM_WAYS-1:0] oh_q, oh_d;
    logic                inv_q, inv_d;
    logic                none_q, none_d;
    logic [NUM_WAYS-1:0] free;
    logic [WAY_W-1:0]    rnd;
    logic                lfsr_en;

    // The random index only moves when a real victim is handed over, so an
    // all-locked response leaves the next request with the same start.
    assign lfsr_en = (state_q == RESP) && rsp_ready_i && !none_q;

    lfsr8_step #(
        .SEED  (SEED),
        .IDX_W (WAY_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .idx   (rnd)
    );

    assign free = ~valid_q & ~lock_q;

    assign req_ready_o   = (state_q == IDLE);
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_way_bin_o = bin_q;
    assign rsp_way_oh_o  = oh_q;
    assign rsp_invalid_o = inv_q;
    assign rsp_none_o    = none_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured request, scan pointer and registered response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            lock_q  <= '0;
            ptr_q   <= '0;
            bin_q   <= '0;
            oh_q    <= '0;
            inv_q   <= 1'b0;
            none_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            bin_q   <= bin_d;
            oh_q    <= oh_d;
            inv_q   <= inv_d;
            none_q  <= none_d;
        end
    end

    // Next-state and datapath decisions; SCAN checks in strict priority order.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        bin_d   = bin_q;
        oh_d    = oh_q;
        inv_d   = inv_q;
        none_d  = none_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    valid_d = way_valid_i;
                    lock_d  = way_lock_i;
                    ptr_d   = rnd;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (|free) begin
                    bin_d   = lowest_set(free);
                    oh_d    = to_onehot(lowest_set(free));
                    inv_d   = 1'b1;
                    none_d  = 1'b0;
                    state_d = RESP;
                end else if (&lock_q) begin
                    bin_d   = '0;
                    oh_d    = '0;
                    inv_d   = 1'b0;
                    none_d  = 1'b1;
                    state_d = RESP;
                end else if (!lock_q[ptr_q]) begin
                    bin_d   = ptr_q;
                    oh_d    = to_onehot(ptr_q);
                    inv_d   = 1'b0;
                    none_d  = 1'b0;
                    state_d = RESP;
                end else begin
                    // Power-of-two way count: natural overflow is the wrap.
                    ptr_d = ptr_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_way_victim_ctrl.sv
module tb_way_victim_ctrl;

    localparam int NW = 4;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] lock;
        logic [1:0] bin;
        logic       inv;
        logic       none;
        int         lat;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] way_valid;
    logic [3:0] way_lock;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] way_bin;
    logic [3:0] way_oh;
    logic       rsp_inv;
    logic       rsp_none;

    int n_vec  = 0;
    int n_miss = 0;

    way_victim_ctrl #(
        .NUM_WAYS (NW),
        .SEED     (8'h00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .way_valid_i   (way_valid),
        .way_lock_i    (way_lock),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_way_bin_o (way_bin),
        .rsp_way_oh_o  (way_oh),
        .rsp_invalid_o (rsp_inv),
        .rsp_none_o    (rsp_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One request/response; inputs are scrambled after accept and during any stall.
    task automatic run(input string nm, input vec_t v, input int stall);
        int         lat;
        logic [3:0] eoh;
        eoh = v.none ? 4'b0000 : (4'b0001 << v.bin);
        chk({nm, " ready_before"}, 32'(req_ready), 32'd1);
        way_valid = v.valid;
        way_lock  = v.lock;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        way_valid = 4'($urandom);
        way_lock  = 4'($urandom);
        chk({nm, " ready_after_accept"}, 32'(req_ready), 32'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            way_valid = 4'($urandom);
            way_lock  = 4'($urandom);
        end while (!rsp_valid && lat < 20);
        chk({nm, " latency"}, 32'(lat), 32'(v.lat));
        chk({nm, " bin"}, 32'(way_bin), 32'(v.bin));
        chk({nm, " onehot"}, 32'(way_oh), 32'(eoh));
        chk({nm, " invalid"}, 32'(rsp_inv), 32'(v.inv));
        chk({nm, " none"}, 32'(rsp_none), 32'(v.none));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            way_valid = 4'($urandom);
            way_lock  = 4'($urandom);
            chk({nm, " stall_valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, " stall_bin"}, 32'(way_bin), 32'(v.bin));
            chk({nm, " stall_onehot"}, 32'(way_oh), 32'(eoh));
            chk({nm, " stall_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({nm, " idle_ready"}, 32'(req_ready), 32'd1);
        chk({nm, " idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tab[12];
    vec_t seq[6];
    vec_t v;

    initial begin
        // LFSR from SEED 0: 00,01,03,06,0D,1B,37,(none holds),37,6F,DE,BD,7A
        tab[0]  = '{4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1};
        tab[1]  = '{4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1};
        tab[2]  = '{4'hF, 4'h0, 2'd1, 1'b0, 1'b0, 1};
        tab[3]  = '{4'hF, 4'h0, 2'd3, 1'b0, 1'b0, 1};
        tab[4]  = '{4'hF, 4'h0, 2'd2, 1'b0, 1'b0, 1};
        tab[5]  = '{4'hB, 4'h0, 2'd2, 1'b1, 1'b0, 1};
        tab[6]  = '{4'hF, 4'hF, 2'd0, 1'b0, 1'b1, 1};
        tab[7]  = '{4'hF, 4'h0, 2'd3, 1'b0, 1'b0, 1};
        tab[8]  = '{4'hF, 4'h8, 2'd0, 1'b0, 1'b0, 2};
        tab[9]  = '{4'h0, 4'h1, 2'd1, 1'b1, 1'b0, 1};
        tab[10] = '{4'hF, 4'h6, 2'd3, 1'b0, 1'b0, 2};
        tab[11] = '{4'h7, 4'h8, 2'd1, 1'b0, 1'b0, 1};

        // After a fresh reset: 00,01,03,06,0D,(none holds),0D,1B
        seq[0] = '{4'hF, 4'hB, 2'd2, 1'b0, 1'b0, 3};
        seq[1] = '{4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1};
        seq[2] = '{4'hF, 4'h0, 2'd1, 1'b0, 1'b0, 1};
        seq[3] = '{4'hF, 4'h7, 2'd3, 1'b0, 1'b0, 1};
        seq[4] = '{4'hF, 4'hF, 2'd0, 1'b0, 1'b1, 1};
        seq[5] = '{4'hF, 4'h0, 2'd2, 1'b0, 1'b0, 1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        way_valid = 4'h0;
        way_lock  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset bin", 32'(way_bin), 32'd0);
        chk("reset onehot", 32'(way_oh), 32'd0);
        chk("reset invalid", 32'(rsp_inv), 32'd0);
        chk("reset none", 32'(rsp_none), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            run($sformatf("tab%0d", i), tab[i], 0);
        end

        do_reset();
        for (int i = 0; i < 6; i++) begin
            run($sformatf("seq%0d", i), seq[i], 0);
        end

        // Stalled consumer: lfsr 1B gives rnd 1.
        v = '{4'hF, 4'h0, 2'd1, 1'b0, 1'b0, 1};
        run("stall", v, 5);

        // Reset while scanning past locked ways.
        do_reset();
        way_valid = 4'hF;
        way_lock  = 4'h7;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midscan rsp_valid_before", 32'(rsp_valid), 32'd0);
        chk("midscan ready_before", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midscan rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midscan rst req_ready", 32'(req_ready), 32'd1);
        chk("midscan rst bin", 32'(way_bin), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = '{4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1};
        run("post_rst0", v, 0);
        run("post_rst1", v, 0);
        v = '{4'hF, 4'h0, 2'd1, 1'b0, 1'b0, 1};
        run("post_rst2", v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
